psram_dev_resp: RTL and testbench
=================================

Name: psram_dev_resp

Overview:
Synthesizable octal-DDR PSRAM device responder: the device end of the psram interface that the axi4_psram controller drives. It connects to the controller's pad wires, oversamples sck on clk_i, decodes command, address and latency phases, and serves sync and mode-register reads and writes from an internal byte array. It is the in-bench device model and doubles as an FPGA loopback target.

Parameters:
MEM_DEPTH, 1024, bytes of storage (power of 2)
ADDR_WIDTH, $clog2(MEM_DEPTH), address bits used (upper address bits ignored)
RD_LATENCY, 5, sck cycles between address and first read data
WR_LATENCY, 1, sck cycles between address and first write data

Ports:
clk_i  in  1  system clock, ≥4× sck frequency
rst_i  in  1  synchronous reset, active-high
psram_sck_i  in  1  device clock from controller
psram_ce_i  in  1  chip enable, active-low
psram_io_in_i  in  8  DQ from controller
psram_io_out_o  out  8  DQ to controller
psram_io_en_o  out  8  DQ output enable, active-low (pad oen polarity)
psram_dqs_in_i  in  1  write data mask (1 = byte masked)
psram_dqs_out_o  out  1  read strobe
psram_dqs_en_o  out  1  DQS output enable, active-low

Behaviour:
- Reset: io_out=0x00, io_en=0xFF, dqs_out=0, dqs_en=1, FSM=IDLE, MR0..MR3=0x00. Memory contents are not reset.
- sck, ce, io_in and dqs_in each pass a 2-flop synchronizer in the same stage, so they stay aligned. An edge is detected by comparing the synchronized sck with its previous value. Each action fires 3 clk_i after the pad edge.
- Sck cycle n: cycle 0 is the first rising edge after ce falls.
  - Cycle 0: command byte on rise; the fall byte is ignored.
  - Cycle 1: address bytes A[31:24] on rise, A[23:16] on fall.
  - Cycle 2: A[15:8] on rise, A[7:0] on fall.
- Commands:
  - 0x00 sync read
  - 0x80 sync write
  - 0x40 reg read
  - 0xC0 reg write
  - Any other command -> ERR.
- Latency: L = RD_LATENCY for reads, WR_LATENCY for writes, 0 for reg commands. Data phase starts at the rising edge of cycle 3+L. Each later edge (rise and fall) is one byte.
- Read: on each data edge, drive mem[addr] onto io_out with io_en=0x00, drive dqs_en=0, set dqs_out=1 on rise and 0 on fall, then addr++. Reg read returns MR[A[1:0]] on every edge.
- Write: on each data edge, store the sampled io_in to mem[addr] unless dqs_in=1, then addr++. Reg write stores the first data byte into MR[A[1:0]] and ignores the rest.
- Address increment: linear, modulo MEM_DEPTH (0x3FF -> 0x000).
- FSM states: IDLE -> CMD (ce low) -> ADDR -> LAT (skipped when L=0) -> RDATA/WDATA. ERR holds outputs released until ce rises.
- ce high at any clk_i (synchronized), from any state, including mid-address or mid-burst:
  - Next clk_i: FSM=IDLE, io_en=0xFF, dqs_en=1, dqs_out=0.
  - A partial write keeps only the bytes already committed.
- Sck edges while ce is high are ignored.
- rst_i mid-transaction: same output release as ce high, FSM=IDLE, MRs cleared.
- Read and write never overlap; the array has one write port and one read port, with no bypass needed.

Optional Feature:
PSRAM_DEV_RESP_WRAP_EN
- Defined: sync read/write bursts wrap within the aligned 32-byte block. Only addr[4:0] increments; upper bits are held (0x01F -> 0x000, 0x03F -> 0x020).
- Undefined: linear increment modulo MEM_DEPTH as above.
- Register commands are unaffected either way.

Test Plan:
- Write then read: sync write 0x80 to addr 0x10 with bytes 11,22,33,44 and dqs_in=0, then sync read of 4 bytes from 0x10 -> io_out returns 11,22,33,44. dqs_out toggles 1,0,1,0, and the first byte appears at the rising edge of cycle 8.
- Masked write: write 0xAA,0xBB to 0x20 with dqs_in high on the second byte (pre-filled 0x55,0x66) -> read returns AA,66.
- Wrap boundary: write 4 bytes starting at 0x3FE -> bytes land at 0x3FE,0x3FF,0x000,0x001. With WRAP_EN and a start at 0x01E, the bytes land at 0x01E,0x01F,0x000,0x001.
- Register access: reg write 0xC0, addr 2, data 0x5A -> reg read 0x40, addr 2 returns 0x5A on every data edge. A reg read of addr 0 after rst_i returns 0x00.
- Abort: raise ce after the 2nd read byte -> one clk_i after the synchronized ce, io_en=0xFF, dqs_en=1 and FSM=IDLE. The next transaction decodes normally.
- Illegal command 0x13 -> io_en stays 0xFF for the whole ce-low window and memory is unchanged.

Source files
------------

// File: rtl/psram_dev_resp_if.sv
// Pad-level bus between the octal-DDR PSRAM controller (master) and the device responder (slave).
`timescale 1ns/1ps
interface psram_dev_resp_if;
  logic       psram_sck;
  logic       psram_ce;
  logic [7:0] psram_io_in;
  logic [7:0] psram_io_out;
  logic [7:0] psram_io_en;
  logic       psram_dqs_in;
  logic       psram_dqs_out;
  logic       psram_dqs_en;

  modport master (
    output psram_sck, psram_ce, psram_io_in, psram_dqs_in,
    input  psram_io_out, psram_io_en, psram_dqs_out, psram_dqs_en
  );

  modport slave (
    input  psram_sck, psram_ce, psram_io_in, psram_dqs_in,
    output psram_io_out, psram_io_en, psram_dqs_out, psram_dqs_en
  );
endinterface

// File: rtl/psram_dev_resp.sv
// Octal-DDR PSRAM device responder: oversamples sck on clk_i, serves sync and mode-register accesses.
// Define PSRAM_DEV_RESP_WRAP_EN to make sync bursts wrap within an aligned 32-byte block.
`timescale 1ns/1ps
module psram_dev_resp #(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int RD_LATENCY = 5,
  parameter int WR_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  psram_dev_resp_if.slave  psram
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_LAT, ST_RDATA, ST_WDATA, ST_ERR
  } state_e;

  logic       sck_s1_q, sck_s2_q, sck_prev_q;
  logic       ce_s1_q, ce_s2_q;
  logic [7:0] io_s1_q, io_s2_q;
  logic       dqs_s1_q, dqs_s2_q;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_inc;
  logic [2:0]              edge_cnt_q, edge_cnt_d;
  logic [7:0]              lat_q, lat_d, lat_cnt_q, lat_cnt_d;
  logic                    is_wr_q, is_wr_d, is_reg_q, is_reg_d;
  logic                    mr_done_q, mr_done_d;
  logic [3:0][7:0]         mr_q, mr_d;
  logic [7:0]              io_out_q, io_out_d, io_en_q, io_en_d;
  logic                    dqs_out_q, dqs_out_d, dqs_en_q, dqs_en_d;

  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic       rise, fall, sck_edge, data_edge;
  state_e     data_state;

  assign rise       = sck_s2_q & ~sck_prev_q;
  assign fall       = ~sck_s2_q & sck_prev_q;
  assign sck_edge   = rise | fall;
  assign mem_rdata  = mem[addr_q];
  assign data_state = is_wr_q ? ST_WDATA : ST_RDATA;

`ifdef PSRAM_DEV_RESP_WRAP_EN
  assign addr_inc = {addr_q[ADDR_WIDTH-1:5], addr_q[4:0] + 5'd1};
`else
  assign addr_inc = addr_q + ADDR_WIDTH'(1);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    edge_cnt_d = edge_cnt_q;
    lat_d      = lat_q;
    lat_cnt_d  = lat_cnt_q;
    is_wr_d    = is_wr_q;
    is_reg_d   = is_reg_q;
    mr_done_d  = mr_done_q;
    mr_d       = mr_q;
    io_out_d   = io_out_q;
    io_en_d    = io_en_q;
    dqs_out_d  = dqs_out_q;
    dqs_en_d   = dqs_en_q;
    mem_we     = 1'b0;
    data_edge  = 1'b0;

    if (ce_s2_q) begin
      state_d   = ST_IDLE;
      io_en_d   = '1;
      dqs_en_d  = 1'b1;
      dqs_out_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_CMD: begin
          state_d = ST_CMD;
          if (rise) begin
            edge_cnt_d = '0;
            lat_cnt_d  = '0;
            mr_done_d  = 1'b0;
            state_d    = ST_ADDR;
            unique case (io_s2_q)
              8'h00:   begin is_wr_d = 1'b0; is_reg_d = 1'b0; lat_d = 8'(RD_LATENCY); end
              8'h80:   begin is_wr_d = 1'b1; is_reg_d = 1'b0; lat_d = 8'(WR_LATENCY); end
              8'h40:   begin is_wr_d = 1'b0; is_reg_d = 1'b1; lat_d = '0; end
              8'hC0:   begin is_wr_d = 1'b1; is_reg_d = 1'b1; lat_d = '0; end
              default: state_d = ST_ERR;
            endcase
          end
        end
        // Edge 0 is the ignored fall byte of the command cycle; edges 1..4 carry A[31:0] MSB first.
        ST_ADDR: begin
          if (sck_edge) begin
            if (edge_cnt_q != 3'd0) addr_d = ADDR_WIDTH'({addr_q, io_s2_q});
            edge_cnt_d = edge_cnt_q + 3'd1;
            if (edge_cnt_q == 3'd4) state_d = (lat_q == 8'd0) ? data_state : ST_LAT;
          end
        end
        // The rise that ends latency is itself the first data edge.
        ST_LAT: begin
          if (rise) begin
            if (lat_cnt_q == lat_q) begin
              data_edge = 1'b1;
              state_d   = data_state;
            end else begin
              lat_cnt_d = lat_cnt_q + 8'd1;
            end
          end
        end
        ST_RDATA, ST_WDATA: data_edge = sck_edge;
        ST_ERR:             state_d = ST_ERR;
        default:            state_d = ST_IDLE;
      endcase

      if (data_edge) begin
        if (is_wr_q) begin
          if (is_reg_q) begin
            if (!mr_done_q) mr_d[addr_q[1:0]] = io_s2_q;
            mr_done_d = 1'b1;
          end else begin
            mem_we = ~dqs_s2_q;
            addr_d = addr_inc;
          end
        end else begin
          io_out_d  = is_reg_q ? mr_q[addr_q[1:0]] : mem_rdata;
          io_en_d   = '0;
          dqs_en_d  = 1'b0;
          dqs_out_d = sck_s2_q;
          if (!is_reg_q) addr_d = addr_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      ce_s1_q    <= 1'b1;
      ce_s2_q    <= 1'b1;
      io_s1_q    <= '0;
      io_s2_q    <= '0;
      dqs_s1_q   <= 1'b0;
      dqs_s2_q   <= 1'b0;
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      edge_cnt_q <= '0;
      lat_q      <= '0;
      lat_cnt_q  <= '0;
      is_wr_q    <= 1'b0;
      is_reg_q   <= 1'b0;
      mr_done_q  <= 1'b0;
      mr_q       <= '0;
      io_out_q   <= '0;
      io_en_q    <= '1;
      dqs_out_q  <= 1'b0;
      dqs_en_q   <= 1'b1;
    end else begin
      sck_s1_q   <= psram.psram_sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      ce_s1_q    <= psram.psram_ce;
      ce_s2_q    <= ce_s1_q;
      io_s1_q    <= psram.psram_io_in;
      io_s2_q    <= io_s1_q;
      dqs_s1_q   <= psram.psram_dqs_in;
      dqs_s2_q   <= dqs_s1_q;
      state_q    <= state_d;
      addr_q     <= addr_d;
      edge_cnt_q <= edge_cnt_d;
      lat_q      <= lat_d;
      lat_cnt_q  <= lat_cnt_d;
      is_wr_q    <= is_wr_d;
      is_reg_q   <= is_reg_d;
      mr_done_q  <= mr_done_d;
      mr_q       <= mr_d;
      io_out_q   <= io_out_d;
      io_en_q    <= io_en_d;
      dqs_out_q  <= dqs_out_d;
      dqs_en_q   <= dqs_en_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[addr_q] <= io_s2_q;
  end

  assign psram.psram_io_out  = io_out_q;
  assign psram.psram_io_en   = io_en_q;
  assign psram.psram_dqs_out = dqs_out_q;
  assign psram.psram_dqs_en  = dqs_en_q;

endmodule

// File: tb/tb_psram_dev_resp.sv
// Self-checking bench for psram_dev_resp: table of pad transactions plus hand-written abort/illegal/reset sequences.
`timescale 1ns/1ps
module tb_psram_dev_resp;
  localparam int RD_LAT = 5;
  localparam int WR_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  psram_dev_resp_if bus ();

  psram_dev_resp #(
    .MEM_DEPTH  (1024),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .psram (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       dqs;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [31:0] addr;
    int          n;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [63:0] rexp;
    bit          chk_lat;
  } vec_t;
  vec_t vecs[$];

  string cur_name = "init";
  logic  drive_seen = 1'b0;
  logic  prev_dqs_out = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each data edge toggles dqs_out while dqs_en is low.
  always @(posedge clk) begin
    rd_exp_t e;
    #1;
    if (bus.psram_io_en !== 8'hFF) drive_seen = 1'b1;
    if (bus.psram_dqs_en === 1'b0 && bus.psram_dqs_out !== prev_dqs_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected/%s: got byte 0x%0h, expected none", cur_name, bus.psram_io_out);
      end else begin
        e = exp_q.pop_front();
        check({"rd_byte/", cur_name},
              {8'h00, bus.psram_io_en, 7'd0, bus.psram_dqs_out, bus.psram_io_out},
              {8'h00, 8'h00, 7'd0, e.dqs, e.data});
      end
    end
    prev_dqs_out = bus.psram_dqs_out;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input logic [7:0] cmd);
    if (cmd == 8'h00) return RD_LAT;
    if (cmd == 8'h80) return WR_LAT;
    return 0;
  endfunction

  function automatic void add_vec(input string name, input logic [7:0] cmd, input logic [31:0] addr,
                                  input int n, input logic [63:0] wd, input logic [7:0] wm,
                                  input logic [63:0] rexp, input bit chk_lat);
    vec_t v;
    v.name = name; v.cmd = cmd; v.addr = addr; v.n = n;
    v.wd = wd; v.wm = wm; v.rexp = rexp; v.chk_lat = chk_lat;
    vecs.push_back(v);
  endfunction

  task automatic sck_edge(input logic lvl, input logic [7:0] d, input logic m);
    bus.psram_io_in  = d;
    bus.psram_dqs_in = m;
    #20;
    bus.psram_sck = lvl;
    #20;
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [31:0] addr, input int n,
                     input logic [63:0] wd, input logic [7:0] wm, input logic [63:0] rexp,
                     input bit chk_lat, input bit chk_rel);
    rd_exp_t e;
    bit is_rd;
    int lat;
    is_rd = (cmd == 8'h00) || (cmd == 8'h40);
    lat   = lat_of(cmd);
    bus.psram_ce = 1'b0;
    #40;
    sck_edge(1'b1, cmd, 1'b0);
    sck_edge(1'b0, 8'h00, 1'b0);
    sck_edge(1'b1, addr[31:24], 1'b0);
    sck_edge(1'b0, addr[23:16], 1'b0);
    sck_edge(1'b1, addr[15:8], 1'b0);
    sck_edge(1'b0, addr[7:0], 1'b0);
    for (int i = 0; i < lat; i++) begin
      sck_edge(1'b1, 8'h00, 1'b0);
      sck_edge(1'b0, 8'h00, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      if (is_rd) begin
        e.data = rexp[8*i +: 8];
        e.dqs  = (i % 2 == 0);
        exp_q.push_back(e);
      end
      sck_edge(i % 2 == 0, wd[8*i +: 8], wm[i]);
      if (chk_lat && i == 0) begin
        check({"lat_not_early/", cur_name}, {31'd0, bus.psram_dqs_en}, 32'd1);
        #10;
        check({"lat_first/", cur_name}, {30'd0, bus.psram_dqs_en, bus.psram_dqs_out}, 32'd1);
      end
    end
    #40;
    bus.psram_ce = 1'b1;
    if (chk_rel) begin
      #20;
      check({"ce_hold/", cur_name}, {23'd0, bus.psram_io_en, bus.psram_dqs_en}, 32'd0);
      #10;
      check({"ce_release/", cur_name},
            {22'd0, bus.psram_io_en, bus.psram_dqs_en, bus.psram_dqs_out}, {22'd0, 8'hFF, 1'b1, 1'b0});
      #10;
    end else begin
      #40;
    end
    bus.psram_sck = 1'b0;
    #80;
  endtask

  initial begin
    bus.psram_sck    = 1'b0;
    bus.psram_ce     = 1'b1;
    bus.psram_io_in  = 8'h00;
    bus.psram_dqs_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_io_out",  {24'd0, bus.psram_io_out}, 32'h00);
    check("rst_io_en",   {24'd0, bus.psram_io_en},  32'hFF);
    check("rst_dqs_out", {31'd0, bus.psram_dqs_out}, 32'd0);
    check("rst_dqs_en",  {31'd0, bus.psram_dqs_en},  32'd1);

    //       name          cmd    addr           n  wdata (byte0 = LSB)    mask   read expect           lat
    add_vec("wr_10",       8'h80, 32'h0000_0010, 4, 64'h44332211,          8'h00, 64'h0,                1'b0);
    add_vec("rd_10_hi",    8'h00, 32'h1234_5C10, 4, 64'h0,                 8'h00, 64'h44332211,         1'b1);
    add_vec("prefill_20",  8'h80, 32'h0000_0020, 2, 64'h6655,              8'h00, 64'h0,                1'b0);
    add_vec("mask_20",     8'h80, 32'h0000_0020, 2, 64'hBBAA,              8'h02, 64'h0,                1'b0);
    add_vec("rd_mask_20",  8'h00, 32'h0000_0020, 2, 64'h0,                 8'h00, 64'h66AA,             1'b0);
    add_vec("wr_3fe",      8'h80, 32'h0000_03FE, 4, 64'h04030201,          8'h00, 64'h0,                1'b0);
    add_vec("rd_3fe",      8'h00, 32'h0000_03FE, 4, 64'h0,                 8'h00, 64'h04030201,         1'b0);
`ifdef PSRAM_DEV_RESP_WRAP_EN
    add_vec("rd_wrap_3e0", 8'h00, 32'h0000_03E0, 2, 64'h0,                 8'h00, 64'h0403,             1'b0);
`else
    add_vec("rd_lin_000",  8'h00, 32'h0000_0000, 2, 64'h0,                 8'h00, 64'h0403,             1'b0);
`endif
    add_vec("wr_01e",      8'h80, 32'h0000_001E, 4, 64'hA4A3A2A1,          8'h00, 64'h0,                1'b0);
    add_vec("rd_01e",      8'h00, 32'h0000_001E, 2, 64'h0,                 8'h00, 64'hA2A1,             1'b0);
`ifdef PSRAM_DEV_RESP_WRAP_EN
    add_vec("rd_000",      8'h00, 32'h0000_0000, 2, 64'h0,                 8'h00, 64'hA4A3,             1'b0);
    add_vec("rd_020",      8'h00, 32'h0000_0020, 2, 64'h0,                 8'h00, 64'h66AA,             1'b0);
`else
    add_vec("rd_000",      8'h00, 32'h0000_0000, 2, 64'h0,                 8'h00, 64'h0403,             1'b0);
    add_vec("rd_020",      8'h00, 32'h0000_0020, 2, 64'h0,                 8'h00, 64'hA4A3,             1'b0);
`endif
    add_vec("mr_wr_2",     8'hC0, 32'h0000_0002, 2, 64'h775A,              8'h00, 64'h0,                1'b0);
    add_vec("mr_rd_2",     8'h40, 32'h0000_0002, 4, 64'h0,                 8'h00, 64'h5A5A5A5A,         1'b0);
    add_vec("mr_rd_3",     8'h40, 32'h0000_0003, 2, 64'h0,                 8'h00, 64'h0000,             1'b0);
    add_vec("prefill_40",  8'h80, 32'h0000_0040, 2, 64'h0201,              8'h00, 64'h0,                1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cur_name = vecs[i].name;
      txn(vecs[i].cmd, vecs[i].addr, vecs[i].n, vecs[i].wd, vecs[i].wm, vecs[i].rexp,
          vecs[i].chk_lat, 1'b0);
    end

    // Read cut by ce after its 2nd byte, then a normal read continues where data lives.
    cur_name = "rd_cut";
    txn(8'h00, 32'h10, 2, 64'h0, 8'h00, 64'h2211, 1'b0, 1'b1);
    cur_name = "rd_after_cut";
    txn(8'h00, 32'h12, 2, 64'h0, 8'h00, 64'h4433, 1'b0, 1'b0);

    // ce rises in the middle of the address phase.
    cur_name = "addr_cut";
    bus.psram_ce = 1'b0;
    #40;
    sck_edge(1'b1, 8'h80, 1'b0);
    sck_edge(1'b0, 8'h00, 1'b0);
    sck_edge(1'b1, 8'h00, 1'b0);
    bus.psram_ce = 1'b1;
    #40;
    bus.psram_sck = 1'b0;
    #80;
    check("addr_cut_io_en", {24'd0, bus.psram_io_en}, 32'hFF);
    cur_name = "mr_rd_after_cut";
    txn(8'h40, 32'h2, 2, 64'h0, 8'h00, 64'h5A5A, 1'b0, 1'b0);

    // Write cut after one committed byte keeps only that byte.
    cur_name = "wr_partial";
    txn(8'h80, 32'h40, 1, 64'hC1, 8'h00, 64'h0, 1'b0, 1'b0);
    cur_name = "rd_partial";
    txn(8'h00, 32'h40, 2, 64'h0, 8'h00, 64'h02C1, 1'b0, 1'b0);

    // Illegal command never drives the bus and never writes.
    cur_name = "illegal_13";
    drive_seen = 1'b0;
    txn(8'h13, 32'h10, 6, 64'hDEADBEEFCAFE, 8'h00, 64'h0, 1'b0, 1'b0);
    check("illegal_no_drive", {31'd0, drive_seen}, 32'd0);
    cur_name = "rd_after_illegal";
    txn(8'h00, 32'h10, 4, 64'h0, 8'h00, 64'h44332211, 1'b0, 1'b0);

    // Mode registers clear on rst_i.
    cur_name = "mr_wr_0";
    txn(8'hC0, 32'h0, 2, 64'h1199, 8'h00, 64'h0, 1'b0, 1'b0);
    cur_name = "mr_rd_0";
    txn(8'h40, 32'h0, 2, 64'h0, 8'h00, 64'h9999, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #40;
    cur_name = "mr_rd_0_rst";
    txn(8'h40, 32'h0, 2, 64'h0, 8'h00, 64'h0000, 1'b0, 1'b0);
    cur_name = "mr_rd_2_rst";
    txn(8'h40, 32'h2, 2, 64'h0, 8'h00, 64'h0000, 1'b0, 1'b0);

    #100;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
